// File: rtl/full_adder.sv
// Ripple-carry adder built from 1-bit full-adder cells, with an optional
// registered copy of the sum and carry-out for pipelined compression trees.
module full_adder #(
  parameter int unsigned WIDTH  = 1,
  parameter bit          REG_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q
);

  // c[i] is the carry into bit i; c[WIDTH] leaves the MSB
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[WIDTH];

  if (REG_EN) begin : g_reg
    // Captures the combinational result one cycle later; cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q    <= '0;
        cout_q <= 1'b0;
      end else begin
        s_q    <= s;
        cout_q <= cout;
      end
    end
  end else begin : g_noreg
    logic unused_reg_in;
    assign unused_reg_in = clk ^ rst_n;
    assign s_q    = '0;
    assign cout_q = 1'b0;
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed checks of full_adder at WIDTH 1, 4 (unregistered) and 8,
// covering the truth table, reset behaviour of the registers and carry wrap.
module tb_full_adder;

  logic clk;
  logic rst_n;

  logic [0:0] a1, b1, s1, s_q1;
  logic       cin1, cout1, cout_q1;
  logic [3:0] a4, b4, s4, s_q4;
  logic       cin4, cout4, cout_q4;
  logic [7:0] a8, b8, s8, s_q8;
  logic       cin8, cout8, cout_q8;

  int checks = 0;
  int errors = 0;

  full_adder #(.WIDTH(1), .REG_EN(1'b1)) u_fa1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1),
    .s(s1), .cout(cout1), .s_q(s_q1), .cout_q(cout_q1)
  );

  full_adder #(.WIDTH(4), .REG_EN(1'b0)) u_fa4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4),
    .s(s4), .cout(cout4), .s_q(s_q4), .cout_q(cout_q4)
  );

  full_adder #(.WIDTH(8), .REG_EN(1'b1)) u_fa8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8),
    .s(s8), .cout(cout8), .s_q(s_q8), .cout_q(cout_q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0] tt_s;
    logic [7:0] tt_cout;
    logic [2:0] v;
    logic [8:0] exp9;
    logic [8:0] prev9;

    tt_s    = 8'b1001_0110;
    tt_cout = 8'b1110_1000;

    rst_n = 1'b0;
    {a1, b1, cin1} = 3'b000;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    #1;
    check("rst_s_q1", 32'(s_q1), 32'd0);
    check("rst_cout_q1", 32'(cout_q1), 32'd0);
    check("rst_s_q8", 32'(s_q8), 32'd0);

    // exhaustive 1-bit sweep, 5 ns per step, reset held
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, cin1} = v;
      #5;
      check($sformatf("sweep_s_%0d", i), 32'(s1), 32'(tt_s[i]));
      check($sformatf("sweep_cout_%0d", i), 32'(cout1), 32'(tt_cout[i]));
    end
    check("rst_hold_s_q1", 32'(s_q1), 32'd0);
    check("rst_hold_cout_q1", 32'(cout_q1), 32'd0);

    // cin toggle with a=b=1
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    #5;
    check("tog0_s", 32'(s1), 32'd0);
    check("tog0_cout", 32'(cout1), 32'd1);
    cin1 = 1'b1;
    #5;
    check("tog1_s", 32'(s1), 32'd1);
    check("tog1_cout", 32'(cout1), 32'd1);
    check("rst_comb_s_q1", 32'(s_q1), 32'd0);

    // release reset, first capture on the next posedge
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1;
    #1;
    check("pre_edge_s_q1", 32'(s_q1), 32'd0);
    check("pre_edge_cout_q1", 32'(cout_q1), 32'd0);
    @(posedge clk); #1;
    check("cap_s_q1", 32'(s_q1), 32'd0);
    check("cap_cout_q1", 32'(cout_q1), 32'd1);

    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(posedge clk); #1;
    check("cap2_s_q1", 32'(s_q1), 32'd1);
    check("cap2_cout_q1", 32'(cout_q1), 32'd1);

    // asynchronous assert, away from any edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_s_q1", 32'(s_q1), 32'd0);
    check("async_cout_q1", 32'(cout_q1), 32'd0);
    check("async_comb_s1", 32'(s1), 32'd1);
    check("async_comb_cout1", 32'(cout1), 32'd1);
    @(posedge clk); #1;
    check("rst_edge_s_q1", 32'(s_q1), 32'd0);
    check("rst_edge_cout_q1", 32'(cout_q1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 4-bit directed vectors; registers are tied off at REG_EN=0
    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
    #5;
    check("w4_wrap_s", 32'(s4), 32'h0);
    check("w4_wrap_cout", 32'(cout4), 32'd1);
    a4 = 4'h5; b4 = 4'h3; cin4 = 1'b0;
    #5;
    check("w4_53_s", 32'(s4), 32'h8);
    check("w4_53_cout", 32'(cout4), 32'd0);
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    #5;
    check("w4_zero_s", 32'(s4), 32'h0);
    check("w4_zero_cout", 32'(cout4), 32'd0);
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    @(posedge clk); #1;
    check("w4_max_s", 32'(s4), 32'hF);
    check("w4_max_cout", 32'(cout4), 32'd1);
    check("w4_noreg_s_q", 32'(s_q4), 32'h0);
    check("w4_noreg_cout_q", 32'(cout_q4), 32'd0);

    // 8-bit boundaries then random vectors, combinational and registered
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    #1;
    check("w8_max", 32'({cout8, s8}), 32'h1FF);
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    #1;
    check("w8_zero", 32'({cout8, s8}), 32'h000);
    @(posedge clk); #1;
    check("w8_zero_q", 32'({cout_q8, s_q8}), 32'h000);

    prev9 = 9'h000;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      cin8 = 1'($urandom_range(0, 1));
      exp9 = 9'(a8) + 9'(b8) + 9'(cin8);
      #1;
      check($sformatf("rand8_q_hold_%0d", i), 32'({cout_q8, s_q8}), 32'(prev9));
      check($sformatf("rand8_%0d", i), 32'({cout8, s8}), 32'(exp9));
      @(posedge clk); #1;
      check($sformatf("rand8_q_%0d", i), 32'({cout_q8, s_q8}), 32'(exp9));
      prev9 = exp9;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
